// File: rtl/vt52_ps2_pkg.sv
// Shared PS/2 types and default timing for the VT52 keyboard path.
// Holds the host-transmit FSM states and frame constants.
package vt52_ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam int INHIBIT_CYCLES_DEF = 2500;
  localparam int FIRST_TIMEOUT_DEF  = 375000;
  localparam int BIT_TIMEOUT_DEF    = 50000;
  localparam int FRAME_BITS         = 10;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte offer handshake into the PS/2 host transmitter.
// master: byte source (data, valid); slave: transmitter (ready).
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/ps2_line_sync.sv
// 2-flop synchronizer for PS/2 clock/data plus clock falling-edge detect.
// Ports: clk, reset, clk_pin, data_pin in; clk_s, data_s, fall out.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic clk_m;
  logic data_m;
  logic clk_q;

  // Lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      clk_q  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= clk_pin;
      clk_s  <= clk_m;
      clk_q  <= clk_s;
      data_m <= data_pin;
      data_s <= data_m;
    end
  end

  assign fall = clk_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data, parity, stop, ACK.
// Ports: clk, reset, up (byte handshake), ps2 pins in, oe/busy/done/error out.
module ps2_host_tx
  import vt52_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int FIRST_TIMEOUT  = FIRST_TIMEOUT_DEF,
  parameter int BIT_TIMEOUT    = BIT_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  ps2_host_tx_if.slave up,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW =
    $clog2(max3(INHIBIT_CYCLES, FIRST_TIMEOUT, BIT_TIMEOUT)) + 1;

  ps2_state_t            state;
  logic [TW-1:0]         tmr;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            nbit;
  logic                  clk_s;
  logic                  data_s;
  logic                  fall;
  logic                  expired;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fall     (fall)
  );

  assign expired  = (tmr == '0);
  assign up.ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // tmr counts the inhibit time, then serves as the device watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmr         <= '0;
      shift       <= '0;
      nbit        <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (up.valid) begin
            state       <= INHIBIT;
            shift       <= {1'b1, ~^up.data, up.data};
            tmr         <= TW'(INHIBIT_CYCLES - 1);
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
          end
        end
        INHIBIT: begin
          if (expired) begin
            state       <= START;
            ps2_data_oe <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        START: begin
          state      <= BITS;
          ps2_clk_oe <= 1'b0;
          tmr        <= TW'(FIRST_TIMEOUT);
          nbit       <= '0;
        end
        BITS: begin
          if (fall) begin
            ps2_data_oe <= ~shift[0];
            shift       <= shift >> 1;
            nbit        <= nbit + 4'd1;
            tmr         <= TW'(BIT_TIMEOUT);
            if (nbit == 4'(FRAME_BITS - 1)) state <= ACK;
          end else if (expired) begin
            state       <= IDLE;
            error       <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ACK: begin
          if (fall) begin
            if (data_s) begin
              state <= IDLE;
              error <= 1'b1;
            end else begin
              state <= WAIT_IDLE;
              tmr   <= TW'(BIT_TIMEOUT);
            end
          end else if (expired) begin
            state       <= IDLE;
            error       <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (expired) begin
            state       <= IDLE;
            error       <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Drives frames, ACK/NACK, silent device, held valid and mid-frame reset.
module tb_ps2_host_tx;

  localparam int IC   = 20;
  localparam int FT   = 400;
  localparam int BT   = 200;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic busy;
  logic done;
  logic error;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_n = 0;
  int err_n = 0;
  int both_n = 0;
  int err_cyc = 0;
  int drop_cyc = 0;
  logic oe_q = 1'b0;

  ps2_host_tx_if up ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (IC),
    .FIRST_TIMEOUT  (FT),
    .BIT_TIMEOUT    (BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .up          (up),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_n++;
    if (error === 1'b1) begin
      err_n++;
      err_cyc = cyc;
    end
    if (done === 1'b1 && error === 1'b1) both_n++;
    if (oe_q === 1'b1 && ps2_clk_oe === 1'b0) drop_cyc = cyc;
    oe_q = ps2_clk_oe;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ($countones(b) % 2 == 0), b};
  endfunction

  task automatic accept(input logic [7:0] b);
    int t;
    t = 0;
    while (up.ready !== 1'b1 && t < 1000) begin
      step();
      t++;
    end
    chk("accept_ready", up.ready, 1);
    up.data  = b;
    up.valid = 1'b1;
    step();
    up.valid = 1'b0;
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_busy", busy, 1);
  endtask

  task automatic inhibit_len(output int n, output int ns);
    n  = 0;
    ns = 0;
    while (ps2_clk_oe === 1'b1 && n < 200) begin
      if (ps2_data_oe === 1'b1) ns++;
      n++;
      step();
    end
  endtask

  task automatic dev_frame(
    input  int         nf,
    input  bit         ack,
    output logic [9:0] got,
    output int         f11
  );
    got = '0;
    f11 = 0;
    step(10);
    for (int i = 0; i < nf; i++) begin
      dev_clk = 1'b0;
      if (i == 10) f11 = cyc;
      step(HALF);
      dev_clk = 1'b1;
      if (i == 10) begin
        dev_data = 1'b1;
      end else begin
        got[i] = ps2_data_in;
        if (i == 9 && ack) begin
          step(10);
          dev_data = 1'b0;
          step(HALF - 10);
        end else begin
          step(HALF);
        end
      end
    end
  endtask

  task automatic wait_end(input int lim, output bit seen);
    int t;
    t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < lim) begin
      step();
      t++;
    end
    seen = (done === 1'b1 || error === 1'b1);
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] b;
    int n, ns, f11, d, d0, e0;
    bit seen;

    up.data  = '0;
    up.valid = 1'b0;
    step(3);
    chk("rst_ready", up.ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    reset = 1'b0;
    step(2);

    d0 = done_n;
    e0 = err_n;
    accept(8'hED);
    inhibit_len(n, ns);
    chk("ed_clk_low", n, IC + 1);
    chk("ed_start_cycles", ns, 1);
    chk("ed_start_bit", ps2_data_oe, 1);
    dev_frame(11, 1'b1, got, f11);
    chk("ed_bits", got, 10'h3ED);
    chk("ed_model", got, frame_of(8'hED));
    wait_end(100, seen);
    chk("ed_end_seen", seen, 1);
    chk("ed_done", done, 1);
    step();
    chk("ed_ready_after", up.ready, 1);
    step(2);
    chk("ed_done_once", done_n - d0, 1);
    chk("ed_no_error", err_n - e0, 0);

    accept(8'h00);
    inhibit_len(n, ns);
    dev_frame(11, 1'b1, got, f11);
    chk("p00_parity", got[8], 1);
    chk("p00_frame", got, frame_of(8'h00));
    wait_end(100, seen);
    chk("p00_done", done, 1);
    step(2);

    accept(8'h01);
    inhibit_len(n, ns);
    dev_frame(11, 1'b1, got, f11);
    chk("p01_parity", got[8], 0);
    chk("p01_frame", got, frame_of(8'h01));
    wait_end(100, seen);
    chk("p01_done", done, 1);
    step(2);

    d0 = done_n;
    accept(8'hFF);
    inhibit_len(n, ns);
    wait_end(FT + 50, seen);
    chk("wd_seen", seen, 1);
    chk("wd_error", error, 1);
    d = cyc - drop_cyc;
    chk("wd_latency", (d == FT || d == FT + 1), 1);
    chk("wd_clk_oe", ps2_clk_oe, 0);
    chk("wd_data_oe", ps2_data_oe, 0);
    step();
    chk("wd_ready_next", up.ready, 1);
    chk("wd_busy_next", busy, 0);
    chk("wd_no_done", done_n - d0, 0);
    step(2);

    d0 = done_n;
    e0 = err_n;
    accept(8'hA5);
    inhibit_len(n, ns);
    dev_frame(11, 1'b0, got, f11);
    step(5);
    chk("nack_frame", got, frame_of(8'hA5));
    chk("nack_error", err_n - e0, 1);
    chk("nack_latency", err_cyc - f11, 3);
    chk("nack_no_done", done_n - d0, 0);
    chk("nack_ready", up.ready, 1);

    accept(8'h55);
    up.data  = 8'hF4;
    up.valid = 1'b1;
    chk("hold_ready_low", up.ready, 0);
    inhibit_len(n, ns);
    chk("hold_clk_low", n, IC + 1);
    dev_frame(11, 1'b1, got, f11);
    chk("hold_first", got, frame_of(8'h55));
    wait_end(100, seen);
    chk("hold_done1", done, 1);
    step();
    chk("hold_accepted", ps2_clk_oe, 1);
    up.valid = 1'b0;
    inhibit_len(n, ns);
    chk("hold_clk_low2", n, IC + 1);
    dev_frame(11, 1'b1, got, f11);
    chk("hold_second", got, frame_of(8'hF4));
    wait_end(100, seen);
    chk("hold_done2", done, 1);
    step(2);

    for (int k = 0; k < 4; k++) begin
      d0 = done_n;
      e0 = err_n;
      b  = 8'($urandom_range(0, 255));
      accept(b);
      inhibit_len(n, ns);
      chk("rnd_clk_low", n, IC + 1);
      dev_frame(11, 1'b1, got, f11);
      chk("rnd_frame", got, frame_of(b));
      wait_end(100, seen);
      chk("rnd_done", done, 1);
      step(2);
      chk("rnd_done_once", done_n - d0, 1);
      chk("rnd_no_error", err_n - e0, 0);
    end

    d0 = done_n;
    e0 = err_n;
    accept(8'hF4);
    inhibit_len(n, ns);
    dev_frame(4, 1'b1, got, f11);
    chk("rst_mid_data_oe", ps2_data_oe, 1);
    chk("rst_mid_busy", busy, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_clk_oe0", ps2_clk_oe, 0);
    chk("rst_mid_data_oe0", ps2_data_oe, 0);
    chk("rst_mid_busy0", busy, 0);
    chk("rst_mid_ready", up.ready, 1);
    reset = 1'b0;
    step(50);
    chk("rst_mid_no_done", done_n - d0, 0);
    chk("rst_mid_no_error", err_n - e0, 0);
    chk("rst_mid_idle_oe", ps2_clk_oe, 0);
    chk("never_both", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the VT52 terminal. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). This is the reverse path of the existing PS/2 receiver. It drives the PS/2 clock and data lines as open-drain pull-downs and runs the full host-initiated frame: inhibit, start, 8 data bits, odd parity, stop, and device ACK. `busy` tells the keyboard receiver to ignore line activity while a frame is in flight.

## Interface
Parameters:
- INHIBIT_CYCLES, 2500: cycles the host holds PS/2 clock low before the start bit (100 µs at 25 MHz).
- FIRST_TIMEOUT, 375000: maximum cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 50000: maximum cycles between consecutive device falling edges (2 ms).

Ports (reset: synchronous, active-high, named `reset`; clock: `clk`):
- clk, in, 1: system clock, 25 MHz.
- reset, in, 1: synchronous, active-high.
- data, in, 8: command byte.
- valid, in, 1: `data` is offered.
- ready, out, 1: block is in IDLE and accepts a byte.
- ps2_clk_in, in, 1: raw PS/2 clock pin level (asynchronous).
- ps2_data_in, in, 1: raw PS/2 data pin level (asynchronous).
- ps2_clk_oe, out, 1: 1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe, out, 1: 1 = pull PS/2 data low; 0 = release.
- busy, out, 1: frame in progress (every state except IDLE).
- done, out, 1: one-cycle pulse when the device ACKed and both lines returned high.
- error, out, 1: one-cycle pulse on timeout or missing ACK.

## Operation
- Input conditioning: both pins pass through a 2-flop synchronizer. `fall` is asserted when the previous synchronized clock was 1 and the current one is 0.
- Byte acceptance: a byte is accepted when valid && ready. On acceptance the block latches the 10-bit shift value {1 (stop), ~^data (odd parity), data}.
- States:
  - IDLE: ready=1, both oe=0. Accepting a byte moves to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then START.
  - START: clk_oe=1, data_oe=1 (start bit) for 1 cycle, then BITS. Entering BITS deasserts clk_oe and loads the watchdog with FIRST_TIMEOUT.
  - BITS: data_oe stays 1 until the first `fall`. On each `fall`: data_oe <= ~shift[0], shift >>= 1, bit count +1, watchdog reloads with BIT_TIMEOUT. After the 10th `fall` (stop placed, data_oe=0), go to ACK.
  - ACK: on the next `fall`, sample synchronized data. A 0 goes to WAIT_IDLE; a 1 fires `error` and goes to IDLE.
  - WAIT_IDLE: when synchronized clock and data are both 1, fire `done` and go to IDLE. The watchdog (BIT_TIMEOUT) applies here too.
- Watchdog expiry in BITS, ACK or WAIT_IDLE: fire `error`, set both oe=0, go to IDLE.
- `fall` is ignored in IDLE, INHIBIT and START.
- No queueing: while busy, `valid` is ignored (ready=0) and the upstream source must hold the byte.
- Counter widths: $clog2 of the largest parameter, +1. The bit counter is 4 bits.

## Timing
- Reset values: ready=1, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_data_oe=0. The state is IDLE and the watchdog is cleared.
- Reset mid-frame: both oe deassert in the cycle after reset is sampled. A partial frame is never resumed, and neither done nor error is emitted.
- Accept-to-clk_oe latency: clk_oe rises 1 cycle after the valid && ready cycle. busy rises in the same cycle.
- clk_oe low-time: INHIBIT_CYCLES + 1 cycles in total, including the START cycle.
- Bit-update latency: data_oe changes 3 cycles after the pin's falling edge (2 synchronizer cycles + 1 register). This is well inside the device's low phase of 30 µs or more.
- done and error are mutually exclusive, last one cycle, and are asserted in the cycle that state becomes IDLE. ready=1 from the following cycle.
- A `fall` in the same cycle as watchdog expiry: the edge wins.

## Structure
- Package vt52_ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE);
  - default timing constants at 25 MHz;
  - the FRAME_BITS=10 constant.
- Sub-module ps2_line_sync contains the 2-flop synchronizer plus falling-edge detect for the clock and the synchronized data. The keyboard receiver can reuse it.

## Test plan
Benches set INHIBIT_CYCLES=20, FIRST_TIMEOUT=400, BIT_TIMEOUT=200. The device model clocks at a 60-cycle period.
- Send 0xED to an ACKing device:
  - clk_oe is low for 21 cycles, then data_oe=1 for the start bit;
  - the device samples 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop 1;
  - ACK is 0, and `done` pulses once after the lines go high;
  - `error` never asserts.
- Send 0x00: the sampled parity bit is 1. Send 0x01: the sampled parity bit is 0.
- Device produces no clock after release: `error` pulses 400–401 cycles after clk_oe drops, both oe=0, and ready=1 on the next cycle.
- Device leaves data high in the ACK slot (NACK): `error` pulses on the 11th falling edge +3 cycles, and `done` never asserts.
- Assert valid with 0xF4 during a frame: ready=0 and the byte is not latched. It is accepted only after `done`, and the next frame carries 0xF4.
- Assert reset after the 4th device falling edge: both oe=0 on the next cycle, busy=0, ready=1, and no done or error pulse.
